// File: rtl/uart_axi_pkg.sv
// Shared register map, field positions and AXI response codes for the UART CSR block.
package uart_axi_pkg;

   localparam int REG_CTRL     = 0;
   localparam int REG_LENGTH   = 1;
   localparam int REG_STATUS   = 2;
   localparam int REG_SCRATCH0 = 3;

   localparam int CTRL_SEND_BIT      = 0;
   localparam int CTRL_ENABLE_BIT    = 1;
   localparam int STATUS_BUSY_BIT    = 0;
   localparam int STATUS_OVERRUN_BIT = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/uart_csr_bank.sv
// UART control/status register bank: CTRL, LENGTH, STATUS (W1C overrun) and scratch
// registers, plus the one-cycle send trigger.
module uart_csr_bank
   import uart_axi_pkg::*;
#(
   parameter int C_NUM_REGS  = 8,
   parameter int C_LEN_WIDTH = 10,
   parameter int IDX_W       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [31:0]            wr_data,
   input  logic [3:0]             wr_strb,
   output logic                   wr_err,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [31:0]            rd_data,
   output logic                   rd_err,
   input  logic                   tx_busy_i,
   output logic [C_LEN_WIDTH-1:0] data_length_o,
   output logic                   sent_trig_o,
   output logic                   enable_o
);

   logic                   enable_q;
   logic                   overrun_q;
   logic                   sent_trig_q;
   logic [C_LEN_WIDTH-1:0] length_q;
   logic [31:0]            scratch_q [REG_SCRATCH0:C_NUM_REGS-1];

   logic [31:0] wr_idx32, rd_idx32, len_merged;
   logic        hit_ctrl, hit_length, hit_status;
   logic        post_en, send_req, trig_n, ovr_set, ovr_clr;
   logic        unused_bits;

   assign wr_idx32   = 32'(wr_idx);
   assign rd_idx32   = 32'(rd_idx);
   assign wr_err     = (wr_idx32 >= 32'(C_NUM_REGS));
   assign hit_ctrl   = wr_en && (wr_idx32 == 32'(REG_CTRL));
   assign hit_length = wr_en && (wr_idx32 == 32'(REG_LENGTH));
   assign hit_status = wr_en && (wr_idx32 == 32'(REG_STATUS));

   // The send decision uses ENABLE as it will be after this very write.
   assign post_en    = wr_strb[0] ? wr_data[CTRL_ENABLE_BIT] : enable_q;
   assign send_req   = hit_ctrl && wr_strb[0] && wr_data[CTRL_SEND_BIT] && post_en;
   assign trig_n     = send_req && !tx_busy_i;
   assign ovr_set    = send_req && tx_busy_i;
   assign ovr_clr    = hit_status && wr_strb[0] && wr_data[STATUS_OVERRUN_BIT];
   assign len_merged = apply_strb(32'(length_q), wr_data, wr_strb);
   assign unused_bits = ^len_merged;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q    <= 1'b0;
         overrun_q   <= 1'b0;
         sent_trig_q <= 1'b0;
         length_q    <= '0;
         for (int i = REG_SCRATCH0; i < C_NUM_REGS; i++) scratch_q[i] <= '0;
      end else begin
         sent_trig_q <= trig_n;
         if (hit_ctrl && wr_strb[0]) enable_q <= wr_data[CTRL_ENABLE_BIT];
         if (hit_length) length_q <= len_merged[C_LEN_WIDTH-1:0];
         if (ovr_set)      overrun_q <= 1'b1;
         else if (ovr_clr) overrun_q <= 1'b0;
         for (int i = REG_SCRATCH0; i < C_NUM_REGS; i++)
            if (wr_en && (wr_idx32 == 32'(i)))
               scratch_q[i] <= apply_strb(scratch_q[i], wr_data, wr_strb);
      end
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (rd_idx32 >= 32'(C_NUM_REGS)) begin
         rd_err = 1'b1;
      end else if (rd_idx32 == 32'(REG_CTRL)) begin
         rd_data[CTRL_ENABLE_BIT] = enable_q;
      end else if (rd_idx32 == 32'(REG_LENGTH)) begin
         rd_data = 32'(length_q);
      end else if (rd_idx32 == 32'(REG_STATUS)) begin
         rd_data[STATUS_BUSY_BIT]    = tx_busy_i;
         rd_data[STATUS_OVERRUN_BIT] = overrun_q;
      end else begin
         for (int i = REG_SCRATCH0; i < C_NUM_REGS; i++)
            if (rd_idx32 == 32'(i)) rd_data = scratch_q[i];
      end
   end

   assign data_length_o = length_q;
   assign enable_o      = enable_q;
   assign sent_trig_o   = sent_trig_q;

endmodule

// File: rtl/uart_axi_csr.sv
// AXI4-Lite slave front end for the UART CSR bank: independent AW/W holding buffers,
// single outstanding write response and single outstanding read response.
module uart_axi_csr
   import uart_axi_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_NUM_REGS         = 8,
   parameter int C_LEN_WIDTH        = 10
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            tx_busy_i,
   output logic [C_LEN_WIDTH-1:0]          data_length_o,
   output logic                            sent_trig_o,
   output logic                            enable_o
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   logic                          aw_full, w_full;
   logic [IDX_W-1:0]              aw_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]                    bresp_q, rresp_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

   logic        aw_hs, w_hs, ar_hs, commit;
   logic        aw_full_n, w_full_n, bvalid_n, rvalid_n;
   logic        wr_err, rd_err;
   logic [31:0] rd_data;
   logic        unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_hs     = S_AXI_AWVALID && awready_q;
   assign w_hs      = S_AXI_WVALID && wready_q;
   assign ar_hs     = S_AXI_ARVALID && arready_q;
   assign commit    = aw_full && w_full;
   assign aw_full_n = !commit && (aw_full || aw_hs);
   assign w_full_n  = !commit && (w_full || w_hs);
   assign bvalid_n  = commit || (bvalid_q && !S_AXI_BREADY);
   assign rvalid_n  = ar_hs || (rvalid_q && !S_AXI_RREADY);

   // Ready flags are registered copies of the next-cycle buffer/response state.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_idx    <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         aw_full   <= aw_full_n;
         w_full    <= w_full_n;
         if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         awready_q <= !aw_full_n && !bvalid_n;
         wready_q  <= !w_full_n && !bvalid_n;
         bvalid_q  <= bvalid_n;
         if (commit) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
         arready_q <= !rvalid_n;
         rvalid_q  <= rvalid_n;
         if (ar_hs) begin
            rdata_q <= rd_data;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   uart_csr_bank #(
      .C_NUM_REGS  (C_NUM_REGS),
      .C_LEN_WIDTH (C_LEN_WIDTH),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk           (S_AXI_ACLK),
      .rst_n         (S_AXI_ARESETN),
      .wr_en         (commit),
      .wr_idx        (aw_idx),
      .wr_data       (w_data),
      .wr_strb       (w_strb),
      .wr_err        (wr_err),
      .rd_idx        (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]),
      .rd_data       (rd_data),
      .rd_err        (rd_err),
      .tx_busy_i     (tx_busy_i),
      .data_length_o (data_length_o),
      .sent_trig_o   (sent_trig_o),
      .enable_o      (enable_o)
   );

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_uart_axi_csr.sv
// Self-checking bench for uart_axi_csr: directed scenarios plus randomized traffic
// checked against a register-map level reference model.
module tb_uart_axi_csr;
   import uart_axi_pkg::*;

   localparam int NREGS = 8;
   localparam int LENW  = 10;
   localparam int AW    = 6;
   localparam logic [31:0] LEN_MASK = (32'd1 << LENW) - 32'd1;

   logic            S_AXI_ACLK = 1'b0;
   logic            S_AXI_ARESETN = 1'b0;
   logic [AW-1:0]   S_AXI_AWADDR = '0;
   logic [2:0]      S_AXI_AWPROT = '0;
   logic            S_AXI_AWVALID = 1'b0;
   logic            S_AXI_AWREADY;
   logic [31:0]     S_AXI_WDATA = '0;
   logic [3:0]      S_AXI_WSTRB = '0;
   logic            S_AXI_WVALID = 1'b0;
   logic            S_AXI_WREADY;
   logic [1:0]      S_AXI_BRESP;
   logic            S_AXI_BVALID;
   logic            S_AXI_BREADY = 1'b0;
   logic [AW-1:0]   S_AXI_ARADDR = '0;
   logic [2:0]      S_AXI_ARPROT = '0;
   logic            S_AXI_ARVALID = 1'b0;
   logic            S_AXI_ARREADY;
   logic [31:0]     S_AXI_RDATA;
   logic [1:0]      S_AXI_RRESP;
   logic            S_AXI_RVALID;
   logic            S_AXI_RREADY = 1'b0;
   logic            tx_busy_i = 1'b0;
   logic [LENW-1:0] data_length_o;
   logic            sent_trig_o;
   logic            enable_o;

   uart_axi_csr #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (AW),
      .C_NUM_REGS         (NREGS),
      .C_LEN_WIDTH        (LENW)
   ) dut (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .tx_busy_i     (tx_busy_i),
      .data_length_o (data_length_o),
      .sent_trig_o   (sent_trig_o),
      .enable_o      (enable_o)
   );

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   int checks = 0;
   int passes = 0;
   int trig_cnt = 0;

   always @(negedge S_AXI_ACLK) if (sent_trig_o) trig_cnt++;

   // Reference model: what each register should read back as.
   bit          m_en;
   bit          m_ovr;
   logic [31:0] m_len;
   logic [31:0] m_scr [NREGS];

   function automatic void model_reset();
      m_en = 0; m_ovr = 0; m_len = '0;
      for (int i = 0; i < NREGS; i++) m_scr[i] = '0;
   endfunction

   function automatic logic [31:0] model_view(input int idx, input bit busy);
      if (idx >= NREGS) return 32'h0;
      case (idx)
         0: return m_en ? 32'h2 : 32'h0;
         1: return m_len;
         2: return {30'h0, m_ovr, busy};
         default: return m_scr[idx];
      endcase
   endfunction

   function automatic void model_write(input int idx, input logic [31:0] data,
                                       input logic [3:0] strb, input bit busy,
                                       output logic [1:0] resp, output bit trig);
      logic [31:0] old, merged;
      trig = 0;
      resp = RESP_OKAY;
      if (idx >= NREGS) begin
         resp = RESP_SLVERR;
         return;
      end
      old = model_view(idx, busy);
      for (int b = 0; b < 4; b++)
         merged[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
      case (idx)
         0: begin
            m_en = merged[1];
            if (strb[0] && data[0] && m_en) begin
               if (busy) m_ovr = 1;
               else      trig = 1;
            end
         end
         1: m_len = merged & LEN_MASK;
         2: if (strb[0] && data[1]) m_ovr = 0;
         default: m_scr[idx] = merged;
      endcase
   endfunction

   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_dly, input bit hold_b,
                            output logic [1:0] resp, output int lat,
                            output bit trig_seen, output bit ok);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_go, w_go;
      ok = 1; lat = -1; trig_seen = 0; resp = 2'bxx;
      S_AXI_AWADDR  = addr;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_WVALID  = (w_dly == 0);
      while (!(aw_done && w_done) && cyc < 40) begin
         @(negedge S_AXI_ACLK);
         aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
         w_go  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge S_AXI_ACLK); #1;
         cyc++;
         if (aw_go) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
         if (w_go)  begin w_done = 1;  S_AXI_WVALID  = 1'b0; end
         if (!w_done && cyc >= w_dly) S_AXI_WVALID = 1'b1;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (!(aw_done && w_done)) begin
         ok = 0;
         return;
      end
      lat = 0;
      while (!S_AXI_BVALID && lat < 20) begin
         @(posedge S_AXI_ACLK); #1;
         lat++;
      end
      if (!S_AXI_BVALID) begin
         ok = 0;
         return;
      end
      trig_seen = sent_trig_o;
      resp = S_AXI_BRESP;
      if (!hold_b) begin
         S_AXI_BREADY = 1'b1;
         @(posedge S_AXI_ACLK); #1;
         S_AXI_BREADY = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
      int n = 0;
      bit go = 0;
      data = 'x; resp = 'x; ok = 0;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      while (!go && n < 20) begin
         @(negedge S_AXI_ACLK);
         go = S_AXI_ARREADY;
         @(posedge S_AXI_ACLK); #1;
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      if (!go) return;
      ok   = S_AXI_RVALID;
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
      S_AXI_RREADY = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic apply_reset();
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      repeat (3) @(posedge S_AXI_ACLK);
      @(negedge S_AXI_ACLK);
      S_AXI_ARESETN = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; bit ok;
      S_AXI_ARESETN = 1'b0;
      #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
           sent_trig_o, enable_o} !== 7'b0)
         $display("FAIL reset_ctrl_outputs: got %b expected 0",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                   S_AXI_RVALID, sent_trig_o, enable_o});
      else passes++;
      checks++;
      if ({S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP, data_length_o} !== '0)
         $display("FAIL reset_data_outputs: rdata %h rresp %b bresp %b len %h expected 0",
                  S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP, data_length_o);
      else passes++;
      apply_reset();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111)
         $display("FAIL reset_ready_after: got %b expected 111",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      else passes++;
      for (int i = 0; i < NREGS; i++) begin
         axi_read(AW'(i * 4), d, r, ok);
         checks++;
         if (!ok || d !== 32'h0 || r !== RESP_OKAY)
            $display("FAIL reset_reg%0d: got ok=%0d data=%h resp=%b expected 1/0/00", i, ok, d, r);
         else passes++;
      end
   endtask

   task automatic test_length();
      logic [1:0] r, er; int lat; bit trig, etrig, ok;
      axi_write(AW'(1 * 4), 32'h3FF, 4'hF, 3, 0, r, lat, trig, ok);
      model_write(1, 32'h3FF, 4'hF, 0, er, etrig);
      checks++;
      if (!ok || lat !== 1)
         $display("FAIL len_bvalid_latency: got ok=%0d lat=%0d expected 1/1", ok, lat);
      else passes++;
      checks++;
      if (r !== RESP_OKAY) $display("FAIL len_bresp: got %b expected %b", r, RESP_OKAY);
      else passes++;
      checks++;
      if (data_length_o !== 10'h3FF)
         $display("FAIL len_output: got %h expected 3ff", data_length_o);
      else passes++;
   endtask

   task automatic test_send();
      logic [1:0] r, er; logic [31:0] d; int lat, t0; bit trig, etrig, ok;
      tx_busy_i = 1'b0;
      t0 = trig_cnt;
      axi_write(AW'(0), 32'h3, 4'hF, 0, 0, r, lat, trig, ok);
      model_write(0, 32'h3, 4'hF, 0, er, etrig);
      repeat (3) @(posedge S_AXI_ACLK);
      #1;
      checks++;
      if (!ok || trig !== 1'b1)
         $display("FAIL send_pulse_after_commit: got ok=%0d trig=%0d expected 1/1", ok, trig);
      else passes++;
      checks++;
      if (trig_cnt - t0 !== 1)
         $display("FAIL send_pulse_width: got %0d cycles expected 1", trig_cnt - t0);
      else passes++;
      axi_read(AW'(0), d, r, ok);
      checks++;
      if (!ok || d !== 32'h2 || enable_o !== 1'b1)
         $display("FAIL send_ctrl_readback: got %h en=%0d expected 2/1", d, enable_o);
      else passes++;
   endtask

   task automatic test_overrun();
      logic [1:0] r, er; logic [31:0] d; int lat, t0; bit trig, etrig, ok;
      tx_busy_i = 1'b1;
      t0 = trig_cnt;
      axi_write(AW'(0), 32'h3, 4'hF, 1, 0, r, lat, trig, ok);
      model_write(0, 32'h3, 4'hF, 1, er, etrig);
      repeat (2) @(posedge S_AXI_ACLK);
      #1;
      checks++;
      if (!ok || trig_cnt - t0 !== 0)
         $display("FAIL overrun_no_pulse: got ok=%0d pulses=%0d expected 1/0", ok, trig_cnt - t0);
      else passes++;
      axi_read(AW'(2 * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h3)
         $display("FAIL overrun_status_set: got %h expected 3", d);
      else passes++;
      axi_write(AW'(2 * 4), 32'h2, 4'hF, 0, 0, r, lat, trig, ok);
      model_write(2, 32'h2, 4'hF, 1, er, etrig);
      axi_read(AW'(2 * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h1)
         $display("FAIL overrun_w1c: got %h expected 1", d);
      else passes++;
      tx_busy_i = 1'b0;
   endtask

   task automatic test_strobe();
      logic [1:0] r, er; logic [31:0] d; int lat; bit trig, etrig, ok;
      axi_write(AW'(3 * 4), 32'hAABBCCDD, 4'hF, 0, 0, r, lat, trig, ok);
      model_write(3, 32'hAABBCCDD, 4'hF, 0, er, etrig);
      axi_write(AW'(3 * 4 + 2), 32'h11223344, 4'h5, 2, 0, r, lat, trig, ok);
      model_write(3, 32'h11223344, 4'h5, 0, er, etrig);
      axi_read(AW'(3 * 4 + 1), d, r, ok);
      checks++;
      if (!ok || d !== 32'hAA22CC44 || r !== RESP_OKAY)
         $display("FAIL strobe_merge: got %h resp %b expected aa22cc44/00", d, r);
      else passes++;
   endtask

   task automatic test_out_of_range();
      logic [1:0] r, er; logic [31:0] d; int lat; bit trig, etrig, ok;
      axi_write(AW'(NREGS * 4), 32'hFFFF_FFFF, 4'hF, 0, 0, r, lat, trig, ok);
      model_write(NREGS, 32'hFFFF_FFFF, 4'hF, 0, er, etrig);
      checks++;
      if (!ok || r !== RESP_SLVERR)
         $display("FAIL oor_bresp: got ok=%0d resp=%b expected 1/10", ok, r);
      else passes++;
      axi_read(AW'(NREGS * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0 || r !== RESP_SLVERR)
         $display("FAIL oor_read: got %h resp %b expected 0/10", d, r);
      else passes++;
      for (int i = 0; i < NREGS; i++) begin
         axi_read(AW'(i * 4), d, r, ok);
         checks++;
         if (!ok || d !== model_view(i, tx_busy_i))
            $display("FAIL oor_unchanged_reg%0d: got %h expected %h", i, d, model_view(i, tx_busy_i));
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [1:0] r, er; logic [31:0] d, data; logic [3:0] strb;
      int lat, idx; bit trig, etrig, ok;
      for (int n = 0; n < 60; n++) begin
         tx_busy_i = ($urandom_range(0, 3) == 0);
         idx  = $urandom_range(0, NREGS);
         data = $urandom;
         strb = 4'($urandom);
         if ($urandom_range(0, 2) != 0) begin
            axi_write(AW'(idx * 4 + $urandom_range(0, 3)), data, strb,
                      $urandom_range(0, 3), 0, r, lat, trig, ok);
            model_write(idx, data, strb, tx_busy_i, er, etrig);
            checks++;
            if (!ok || lat !== 1 || r !== er || trig !== etrig)
               $display("FAIL rand_write idx%0d: got ok=%0d lat=%0d resp=%b trig=%0d expected 1/1/%b/%0d",
                        idx, ok, lat, r, trig, er, etrig);
            else passes++;
            checks++;
            if (data_length_o !== m_len[LENW-1:0] || enable_o !== m_en)
               $display("FAIL rand_outputs: got len=%h en=%0d expected %h/%0d",
                        data_length_o, enable_o, m_len[LENW-1:0], m_en);
            else passes++;
         end else begin
            axi_read(AW'(idx * 4 + $urandom_range(0, 3)), d, r, ok);
            checks++;
            if (!ok || d !== model_view(idx, tx_busy_i) ||
                r !== ((idx >= NREGS) ? RESP_SLVERR : RESP_OKAY))
               $display("FAIL rand_read idx%0d: got ok=%0d data=%h resp=%b expected %h",
                        idx, ok, d, r, model_view(idx, tx_busy_i));
            else passes++;
         end
      end
      tx_busy_i = 1'b0;
   endtask

   task automatic test_b_hold_reset();
      logic [1:0] r; int lat; bit trig, ok;
      axi_write(AW'(4 * 4), 32'h5A5A_0001, 4'hF, 0, 1, r, lat, trig, ok);
      checks++;
      if (!ok) $display("FAIL bhold_write_started: got ok=%0d expected 1", ok);
      else passes++;
      S_AXI_AWADDR = AW'(5 * 4); S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WVALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge S_AXI_ACLK); #1;
         checks++;
         if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100)
            $display("FAIL bhold_cycle%0d: got bvalid/awready/wready=%b expected 100",
                     c, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
         else passes++;
      end
      S_AXI_ARESETN = 1'b0;
      #1;
      checks++;
      if (S_AXI_BVALID !== 1'b0)
         $display("FAIL bhold_async_reset: got bvalid=%0d expected 0", S_AXI_BVALID);
      else passes++;
      apply_reset();
   endtask

   task automatic test_abort_then_normal();
      logic [1:0] r; logic [31:0] d; int lat; bit trig, ok;
      S_AXI_AWADDR = AW'(5 * 4); S_AXI_AWVALID = 1'b1;
      @(posedge S_AXI_ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      #2;
      S_AXI_ARESETN = 1'b0;
      #1;
      S_AXI_WVALID = 1'b0;
      apply_reset();
      axi_write(AW'(6 * 4), 32'h0BAD_F00D, 4'hF, 1, 0, r, lat, trig, ok);
      checks++;
      if (!ok || lat !== 1 || r !== RESP_OKAY)
         $display("FAIL abort_first_write: got ok=%0d lat=%0d resp=%b expected 1/1/00", ok, lat, r);
      else passes++;
      axi_read(AW'(6 * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0BAD_F00D) $display("FAIL abort_reg6: got %h expected 0badf00d", d);
      else passes++;
      axi_read(AW'(5 * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0) $display("FAIL abort_reg5: got %h expected 0", d);
      else passes++;
      axi_read(AW'(4 * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0) $display("FAIL abort_reg4_cleared: got %h expected 0", d);
      else passes++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_length();
      test_send();
      test_overrun();
      test_strobe();
      test_out_of_range();
      test_random();
      test_b_hold_reset();
      test_abort_then_normal();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
